// File: rtl/rxframe.sv
// Frame decoder + receive FIFO behind rxshift: checks parity/framing, queues {frm,par,byte}.
// Optional macro RXFRAME_ERRCNT_EN adds o_Err_Cnt, a saturating count of errored entries stored.
module rxframe #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              i_Pclk,
    input  logic              i_Rst,
    input  logic [10:0]       i_Frame,
    input  logic              i_Done,
    output logic [7:0]        o_Byte,
    output logic              o_Par_Err,
    output logic              o_Frm_Err,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Overrun,
    input  logic              i_Clr,
`ifdef RXFRAME_ERRCNT_EN
    output logic [7:0]        o_Err_Cnt,
`endif
    output logic [ADDR_W:0]   o_Count
);

    typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;

    state_t            state, state_nxt;
    logic              done_q;
    logic [10:0]       frame_q;
    logic              par_q, frm_q;
    logic [9:0]        storage [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              latch, check, push_slot;
    logic              full, pop, write;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        check     = 1'b0;
        push_slot = 1'b0;
        case (state)
            IDLE: begin
                if (i_Done && !done_q) begin
                    latch     = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                check     = 1'b1;
                state_nxt = PUSH;
            end
            PUSH: begin
                push_slot = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign pop   = o_Valid && i_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign write = push_slot && (!full || pop);

    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= i_Done;
            if (write) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({write, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (push_slot && full && !pop) overrun <= 1'b1;
            else if (i_Clr)                overrun <= 1'b0;
        end
    end

    always_ff @(posedge i_Pclk) begin
        if (latch) frame_q <= i_Frame;
        if (check) begin
            par_q <= ((^frame_q[9:1]) != PARITY_ODD);
            frm_q <= (frame_q[0] != 1'b0) || (frame_q[10] != 1'b1);
        end
        if (write) storage[wr_ptr] <= {frm_q, par_q, frame_q[8:1]};
    end

`ifdef RXFRAME_ERRCNT_EN
    logic [7:0] err_cnt;
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst)
            err_cnt <= '0;
        else if (i_Clr)
            err_cnt <= '0;
        else if (write && (par_q || frm_q) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
    assign o_Err_Cnt = err_cnt;
`endif

    // Head is gated so stale storage never shows while empty.
    assign o_Valid   = (count != '0);
    assign o_Byte    = o_Valid ? storage[rd_ptr][7:0] : 8'h00;
    assign o_Par_Err = o_Valid ? storage[rd_ptr][8]   : 1'b0;
    assign o_Frm_Err = o_Valid ? storage[rd_ptr][9]   : 1'b0;
    assign o_Overrun = overrun;
    assign o_Count   = count;

endmodule

// File: tb/tb_rxframe.sv
// Bench for rxframe: transaction-level reference model checked every cycle plus literal expectations.
module tb_rxframe;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] frame = '0;
    logic        done = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  byte_o;
    logic        par_err, frm_err, valid, overrun;
    logic [ADDR_W:0] count;
`ifdef RXFRAME_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rxframe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PARITY_ODD(1'b0)) dut (
        .i_Pclk   (clk),
        .i_Rst    (rst),
        .i_Frame  (frame),
        .i_Done   (done),
        .o_Byte   (byte_o),
        .o_Par_Err(par_err),
        .o_Frm_Err(frm_err),
        .o_Valid  (valid),
        .i_Ready  (ready),
        .o_Overrun(overrun),
        .i_Clr    (clr),
`ifdef RXFRAME_ERRCNT_EN
        .o_Err_Cnt(err_cnt),
`endif
        .o_Count  (count)
    );

    always #5 clk = ~clk;

    // Reference model: entries are predicted from the frame rules, written two
    // edges after an accepted rising edge of done; further edges are ignored until then.
    logic [9:0] mq[$];
    bit         m_ov = 1'b0;
    int         m_errcnt = 0;
    bit         m_done_prev = 1'b0;
    bit         m_pending = 1'b0;
    logic [9:0] m_entry = '0;
    longint     m_cyc = 0;
    longint     m_wr_cyc = 0;

    function automatic logic [9:0] decode(input logic [10:0] f);
        logic pe, fe;
        pe = ($countones(f[9:1]) % 2) != 0;
        fe = (f[0] != 1'b0) || (f[10] != 1'b1);
        return {fe, pe, f[8:1]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_errcnt = 0;
            m_done_prev = 1'b0;
            m_pending = 1'b0;
        end else begin
            bit busy, pop_now, full_now, set_ov;
            busy     = m_pending;
            full_now = (mq.size() == DEPTH);
            pop_now  = (mq.size() > 0) && ready;
            set_ov   = 1'b0;
            if (pop_now) void'(mq.pop_front());
            if (m_pending && m_cyc == m_wr_cyc) begin
                if (!full_now || pop_now) begin
                    mq.push_back(m_entry);
                    if ((m_entry[9] || m_entry[8]) && m_errcnt < 255 && !clr) m_errcnt++;
                end else begin
                    set_ov = 1'b1;
                end
                m_pending = 1'b0;
            end
            if (clr) m_errcnt = 0;
            if (done && !m_done_prev && !busy) begin
                m_pending = 1'b1;
                m_entry   = decode(frame);
                m_wr_cyc  = m_cyc + 2;
            end
            if (set_ov) m_ov = 1'b1;
            else if (clr) m_ov = 1'b0;
            m_done_prev = done;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            logic [9:0] e;
            e = (mq.size() > 0) ? mq[0] : 10'h000;
            checks++;
            if (valid !== (mq.size() > 0) || count !== (ADDR_W+1)'(mq.size()) || overrun !== m_ov
                || byte_o !== e[7:0] || par_err !== e[8] || frm_err !== e[9]) begin
                errors++;
                $display("FAIL model t=%0t got v=%0b cnt=%0d ov=%0b byte=%h pe=%0b fe=%0b want v=%0b cnt=%0d ov=%0b byte=%h pe=%0b fe=%0b",
                         $time, valid, count, overrun, byte_o, par_err, frm_err,
                         mq.size() > 0, mq.size(), m_ov, e[7:0], e[8], e[9]);
            end
`ifdef RXFRAME_ERRCNT_EN
            checks++;
            if (err_cnt !== 8'(m_errcnt)) begin
                errors++;
                $display("FAIL model_errcnt got %0d want %0d", err_cnt, m_errcnt);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    endfunction

    // Pulse done for one cycle; returns just after the write edge.
    task automatic send(input logic [10:0] f);
        frame = f;
        done  = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop1();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick();

        send(11'b10100011010);
        chk("good_valid", valid, 1'b1);
        chk("good_byte", byte_o, 8'h8D);
        chk("good_par", par_err, 1'b0);
        chk("good_frm", frm_err, 1'b0);
        chk("good_count", count, 3'd1);
        pop1();
        chk("good_popped", valid, 1'b0);
        tick();

        send(11'b11100011010);
        chk("par_byte", byte_o, 8'h8D);
        chk("par_flag", par_err, 1'b1);
        pop1();
        tick();
        send(11'b00100011010);
        chk("frm_flag", frm_err, 1'b1);
        chk("frm_par", par_err, 1'b0);
        pop1();
`ifdef RXFRAME_ERRCNT_EN
        chk("err_cnt", err_cnt, 8'd2);
`endif
        tick();

        for (int i = 1; i <= 5; i++) begin
            send(mk(8'(i), 1'b0, 1'b0));
            tick();
        end
        chk("ovf_count", count, 3'd4);
        chk("ovf_flag", overrun, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", byte_o, 32'(i));
            pop1();
        end
        chk("ovf_empty", valid, 1'b0);
        chk("ovf_sticky", overrun, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", overrun, 1'b0);
        tick();

        for (int i = 0; i < 4; i++) begin
            send(mk(8'(8'h10 + i), 1'b0, 1'b0));
            tick();
        end
        frame = mk(8'h66, 1'b0, 1'b0);
        done  = 1'b1;
        tick();
        done = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("full_pp_count", count, 3'd4);
        chk("full_pp_ov", overrun, 1'b0);
        chk("full_pp_d0", byte_o, 8'h11);
        pop1();
        chk("full_pp_d1", byte_o, 8'h12);
        pop1();
        chk("full_pp_d2", byte_o, 8'h13);
        pop1();
        chk("full_pp_last", byte_o, 8'h66);
        pop1();
        tick();

        frame = mk(8'h5A, 1'b0, 1'b0);
        done  = 1'b1;
        repeat (20) tick();
        done = 1'b0;
        repeat (3) tick();
        chk("level_count", count, 3'd1);
        chk("level_byte", byte_o, 8'h5A);
        pop1();
        tick();

        send(mk(8'hA1, 1'b0, 1'b0));
        send(mk(8'hA2, 1'b0, 1'b0));
        chk("pre_rst_count", count, 3'd2);
        frame = mk(8'hA3, 1'b0, 1'b0);
        done  = 1'b1;
        tick();
        done = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_valid", valid, 1'b0);
        chk("async_count", count, 3'd0);
        chk("async_byte", byte_o, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_count", count, 3'd0);
        chk("post_rst_valid", valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
